// File: rtl/id_ex_reg_if.sv
// riscv_pkg: shared decode-control and E-stage bundle types.
// id_ex_if: D->E pipeline register bus (decode-side inputs, E-stage outputs,
// stall/flush controls and the bubble counter).
package riscv_pkg;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
        logic       jump;
        logic       branch;
        logic       alu_src;
        logic [1:0] imm_src;
    } ctrl_s;

    typedef struct packed {
        logic        valid;
        ctrl_s       ctrl;
        logic [1:0]  alu_op;
        logic [2:0]  funct3;
        logic        funct7b5;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm_ext;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
    } stage_s;

endpackage

interface id_ex_if;
    import riscv_pkg::*;

    logic        stall_e;
    logic        flush_e;

    logic        valid_d;
    ctrl_s       ctrl_d;
    logic [1:0]  alu_op_d;
    logic [2:0]  funct3_d;
    logic        funct7b5_d;
    logic [31:0] rd1_d, rd2_d, imm_ext_d, pc_d, pc_plus4_d;
    logic [4:0]  rs1_d, rs2_d, rd_d;

    logic        valid_e;
    ctrl_s       ctrl_e;
    logic [1:0]  alu_op_e;
    logic [2:0]  funct3_e;
    logic        funct7b5_e;
    logic [31:0] rd1_e, rd2_e, imm_ext_e, pc_e, pc_plus4_e;
    logic [4:0]  rs1_e, rs2_e, rd_e;

    logic [31:0] bubble_cnt;

    modport master (
        output stall_e, flush_e,
        output valid_d, ctrl_d, alu_op_d, funct3_d, funct7b5_d,
        output rd1_d, rd2_d, imm_ext_d, pc_d, pc_plus4_d, rs1_d, rs2_d, rd_d,
        input  valid_e, ctrl_e, alu_op_e, funct3_e, funct7b5_e,
        input  rd1_e, rd2_e, imm_ext_e, pc_e, pc_plus4_e, rs1_e, rs2_e, rd_e,
        input  bubble_cnt
    );

    modport slave (
        input  stall_e, flush_e,
        input  valid_d, ctrl_d, alu_op_d, funct3_d, funct7b5_d,
        input  rd1_d, rd2_d, imm_ext_d, pc_d, pc_plus4_d, rs1_d, rs2_d, rd_d,
        output valid_e, ctrl_e, alu_op_e, funct3_e, funct7b5_e,
        output rd1_e, rd2_e, imm_ext_e, pc_e, pc_plus4_e, rs1_e, rs2_e, rd_e,
        output bubble_cnt
    );

endinterface

// File: rtl/id_ex_reg.sv
// id_ex_reg: decode-to-execute pipeline register.
// Priority per edge: rst > flush_e > stall_e > load. A flush or reset loads
// an all-zero bubble so no register write, memory write, branch, jump or
// forwarding/hazard match can come from the slot. An invalid decode slot
// loads with its control fields zeroed. Outputs are straight flop outputs.
// Optional bubble counter enabled by defining ID_EX_PERF_EN; otherwise
// bubble_cnt is tied to 0 and no counter flops exist.
module id_ex_reg
    import riscv_pkg::*;
(
    input logic     clk,
    input logic     rst,
    id_ex_if.slave  bus
);

    stage_s d;
    stage_s e_q;

    assign d = '{
        valid:    bus.valid_d,
        ctrl:     bus.ctrl_d,
        alu_op:   bus.alu_op_d,
        funct3:   bus.funct3_d,
        funct7b5: bus.funct7b5_d,
        rd1:      bus.rd1_d,
        rd2:      bus.rd2_d,
        imm_ext:  bus.imm_ext_d,
        pc:       bus.pc_d,
        pc_plus4: bus.pc_plus4_d,
        rs1:      bus.rs1_d,
        rs2:      bus.rs2_d,
        rd:       bus.rd_d
    };

    // Stage register: bubble on reset/flush, hold on stall, else load with
    // side-effecting control squashed for invalid slots.
    always_ff @(posedge clk) begin
        if (rst || bus.flush_e) begin
            e_q <= '0;
        end else if (!bus.stall_e) begin
            e_q <= d;
            if (!bus.valid_d) begin
                e_q.ctrl   <= '0;
                e_q.alu_op <= '0;
            end
        end
    end

    assign bus.valid_e    = e_q.valid;
    assign bus.ctrl_e     = e_q.ctrl;
    assign bus.alu_op_e   = e_q.alu_op;
    assign bus.funct3_e   = e_q.funct3;
    assign bus.funct7b5_e = e_q.funct7b5;
    assign bus.rd1_e      = e_q.rd1;
    assign bus.rd2_e      = e_q.rd2;
    assign bus.imm_ext_e  = e_q.imm_ext;
    assign bus.pc_e       = e_q.pc;
    assign bus.pc_plus4_e = e_q.pc_plus4;
    assign bus.rs1_e      = e_q.rs1;
    assign bus.rs2_e      = e_q.rs2;
    assign bus.rd_e       = e_q.rd;

`ifdef ID_EX_PERF_EN
    logic [31:0] bubble_q;
    logic        valid_nxt;

    // Value valid_e will take after this edge (reset handled in the counter).
    always_comb begin
        valid_nxt = bus.valid_d;
        if (bus.flush_e)      valid_nxt = 1'b0;
        else if (bus.stall_e) valid_nxt = e_q.valid;
    end

    // Count cycles that leave a bubble in E; saturate instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_q <= '0;
        end else if (!valid_nxt && (bubble_q != 32'hFFFF_FFFF)) begin
            bubble_q <= bubble_q + 32'd1;
        end
    end

    assign bus.bubble_cnt = bubble_q;
`else
    assign bus.bubble_cnt = '0;
`endif

endmodule

// File: doc/id_ex_reg.md
ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001: clk  input  1  single clock; all state updates on rising edge.
REQ-002: rst  input  1  synchronous, active-high reset.
REQ-003: stall_e  input  1  hold all E-stage registers at current value.
REQ-004: flush_e  input  1  load a bubble into the E stage.
REQ-005: valid_d  input  1  decode-stage instruction valid.
REQ-006: ctrl_d  input  riscv_pkg::ctrl_s  decoded control bundle (RegWrite, ResultSrc, MemWrite, Jump, Branch, ALUSrc, ImmSrc).
REQ-007: alu_op_d  input  2  ALU-decoder hint; funct3_d  input  3; funct7b5_d  input  1.
REQ-008: rd1_d, rd2_d, imm_ext_d, pc_d, pc_plus4_d  input  32 each  operands, extended immediate, PC values.
REQ-009: rs1_d, rs2_d, rd_d  input  5 each  register addresses for forwarding and hazard logic.
REQ-010: Outputs valid_e, ctrl_e, alu_op_e, funct3_e, funct7b5_e, rd1_e, rd2_e, imm_ext_e, pc_e, pc_plus4_e, rs1_e, rs2_e, rd_e: same widths, registered copies of the _d inputs.
REQ-011: bubble_cnt  output  32  count of E-stage bubble cycles (see Configuration).

Function
REQ-012: Per edge, priority SHALL be rst > flush_e > stall_e > load.
REQ-013: Load: every _e register SHALL take its _d input; latency exactly 1 cycle.
REQ-014: Stall (stall_e=1, flush_e=0): every _e register SHALL hold its value.
REQ-015: Flush: valid_e, ctrl_e (all fields), alu_op_e SHALL be 0; rd_e, rs1_e, rs2_e SHALL be 0 so no forwarding or hazard match occurs; data fields (rd1_e, rd2_e, imm_ext_e, pc_e, pc_plus4_e, funct3_e, funct7b5_e) SHALL be 0.
REQ-016: flush_e and stall_e both asserted SHALL flush; the held instruction is discarded.
REQ-017: Load with valid_d=0 SHALL force ctrl_e=0, alu_op_e=0 and valid_e=0 regardless of ctrl_d, so an invalid slot never writes registers or memory, branches or jumps.
REQ-018: ctrl_e.RegWrite=1 with rd_d=0 SHALL pass through unmodified; x0 suppression happens at writeback.
REQ-019: The block SHALL be purely registered: no combinational path from any input to any output.
REQ-020: A bubble cycle is a cycle in which valid_e=0 after the edge; bubble_cnt SHALL increment by 1 per bubble cycle and saturate at 0xFFFFFFFF, never wrapping.
REQ-021: bubble_cnt SHALL not increment on the reset edge and SHALL hold during stall when valid_e=1.

Reset
REQ-022: With rst=1 at an edge, all _e outputs and bubble_cnt SHALL be 0, equivalent to a bubble plus counter clear.
REQ-023: Reset asserted mid-stall or mid-flush SHALL override both; the first post-reset edge behaves per REQ-012.

Configuration
REQ-024: Macro ID_EX_PERF_EN defined: bubble_cnt SHALL be implemented per REQ-020/021.
REQ-025: Macro ID_EX_PERF_EN undefined: no counter flops SHALL exist; bubble_cnt SHALL be constant 0; all other behaviour SHALL be identical.

Verification
REQ-026: rst=1 for 2 cycles, then release with valid_d=0 -> all outputs 0, and bubble_cnt=1 after the first post-reset edge (PERF_EN).
REQ-027: Load R-type (RegWrite=1, alu_op_d=2'b10, rd_d=5, rd1_d=0x11, rd2_d=0x22) -> the next cycle shows identical _e values and valid_e=1.
REQ-028: Hold lw (ResultSrc=2'b01, imm_ext_d=0x4) with stall_e=1 for 3 cycles while _d inputs change -> _e outputs unchanged for all 3 cycles.
REQ-029: flush_e=1 and stall_e=1 together with a beq in E -> next cycle ctrl_e=0, rd_e=0, valid_e=0, and bubble_cnt increments by 1.
REQ-030: Jal with valid_d=0 -> ctrl_e.Jump=0, ctrl_e.RegWrite=0, valid_e=0.
REQ-031: Preload bubble_cnt to 0xFFFFFFFE via hierarchical force, then apply 3 flushes -> reads 0xFFFFFFFF and holds; repeat without ID_EX_PERF_EN -> constant 0.
